// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing constants and the shared per-axis phase type.
// Rev 1.0
`default_nettype none

package vga_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned DEF_CLK_DIV = 2;

    localparam int unsigned DEF_H_VIS  = 640;
    localparam int unsigned DEF_H_FP   = 16;
    localparam int unsigned DEF_H_SYNC = 96;
    localparam int unsigned DEF_H_BP   = 48;

    localparam int unsigned DEF_V_VIS  = 480;
    localparam int unsigned DEF_V_FP   = 10;
    localparam int unsigned DEF_V_SYNC = 2;
    localparam int unsigned DEF_V_BP   = 33;

    // One enum serves both axes: H_VISIBLE/V_VISIBLE map to PH_VISIBLE, and so on.
    typedef enum logic [1:0] {
        PH_VISIBLE = 2'd0,
        PH_FRONT   = 2'd1,
        PH_SYNCP   = 2'd2,
        PH_BACK    = 2'd3
    } phase_e;

endpackage

`default_nettype wire

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt: one timing axis -- wrapping position counter plus its phase FSM.
// Rev 1.0
`default_nettype none

module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int unsigned VIS  = DEF_H_VIS,
    parameter int unsigned FP   = DEF_H_FP,
    parameter int unsigned SYNC = DEF_H_SYNC,
    parameter int unsigned BP   = DEF_H_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_adv,
    output logic [CNT_W-1:0] o_cnt,
    output phase_e           o_phase
);

    localparam int unsigned TOTAL = VIS + FP + SYNC + BP;

    // Each phase ends on the last count before the next phase's first position.
    localparam logic [CNT_W-1:0] C_VIS_LAST   = CNT_W'(VIS - 1);
    localparam logic [CNT_W-1:0] C_FRONT_LAST = CNT_W'(VIS + FP - 1);
    localparam logic [CNT_W-1:0] C_SYNC_LAST  = CNT_W'(VIS + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] C_LAST       = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    phase_e           state_q, state_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_adv) begin
            cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_adv) begin
            unique case (state_q)
                PH_VISIBLE: if (cnt_q == C_VIS_LAST)   state_d = PH_FRONT;
                PH_FRONT:   if (cnt_q == C_FRONT_LAST) state_d = PH_SYNCP;
                PH_SYNCP:   if (cnt_q == C_SYNC_LAST)  state_d = PH_BACK;
                PH_BACK:    if (cnt_q == C_LAST)       state_d = PH_VISIBLE;
                default:                               state_d = PH_VISIBLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            state_q <= PH_VISIBLE;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign o_cnt   = cnt_q;
    assign o_phase = state_q;

endmodule

`default_nettype wire

// File: rtl/vga_sync.sv
// vga_sync: pixel-rate divider, horizontal/vertical axis counters and registered sync outputs.
// Rev 1.0
`default_nettype none

module vga_sync
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV,
    parameter int unsigned H_VIS   = DEF_H_VIS,
    parameter int unsigned H_FP    = DEF_H_FP,
    parameter int unsigned H_SYNC  = DEF_H_SYNC,
    parameter int unsigned H_BP    = DEF_H_BP,
    parameter int unsigned V_VIS   = DEF_V_VIS,
    parameter int unsigned V_FP    = DEF_V_FP,
    parameter int unsigned V_SYNC  = DEF_V_SYNC,
    parameter int unsigned V_BP    = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst,
    output logic             o_pix_valid,
    output logic [CNT_W-1:0] o_col,
    output logic [CNT_W-1:0] o_row,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_pix_tick,
    output logic             o_frame_start
);

    localparam int unsigned      DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] C_H_LAST   = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             w_tick;
    logic             w_v_adv;
    logic [CNT_W-1:0] w_h_cnt, w_v_cnt;
    phase_e           w_h_phase, w_v_phase;

    // With CLK_DIV=1 the divider is pinned at 0, which equals C_DIV_LAST, so tick never drops.
    assign w_tick  = (div_q == C_DIV_LAST);
    assign w_v_adv = w_tick && (w_h_cnt == C_H_LAST);

    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (w_tick) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    vga_axis_cnt #(
        .VIS  (H_VIS),
        .FP   (H_FP),
        .SYNC (H_SYNC),
        .BP   (H_BP)
    ) u_h_axis (
        .clk     (clk),
        .rst     (rst),
        .i_adv   (w_tick),
        .o_cnt   (w_h_cnt),
        .o_phase (w_h_phase)
    );

    vga_axis_cnt #(
        .VIS  (V_VIS),
        .FP   (V_FP),
        .SYNC (V_SYNC),
        .BP   (V_BP)
    ) u_v_axis (
        .clk     (clk),
        .rst     (rst),
        .i_adv   (w_v_adv),
        .o_cnt   (w_v_cnt),
        .o_phase (w_v_phase)
    );

    // Outputs present the state held before each edge; div_q==0 marks the first clk of a pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_pix_valid   <= 1'b0;
            o_col         <= '0;
            o_row         <= '0;
            o_hsync       <= 1'b1;
            o_vsync       <= 1'b1;
            o_pix_tick    <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_pix_valid   <= (w_h_phase == PH_VISIBLE) && (w_v_phase == PH_VISIBLE);
            o_col         <= w_h_cnt;
            o_row         <= w_v_cnt;
            o_hsync       <= (w_h_phase != PH_SYNCP);
            o_vsync       <= (w_v_phase != PH_SYNCP);
            o_pix_tick    <= w_tick;
            o_frame_start <= (w_h_cnt == '0) && (w_v_cnt == '0) && (div_q == '0);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_sync.sv
// tb_vga_sync: two reduced-timing instances (CLK_DIV=2 and CLK_DIV=1) checked every clk
// against an arithmetic model of raster position derived from clocks since reset release.
`default_nettype none

module tb_vga_sync;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    typedef struct {
        int valid;
        int col;
        int row;
        int hs;
        int vs;
        int tick;
        int fs;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       a_valid, a_hs, a_vs, a_tick, a_fs;
    logic [9:0] a_col, a_row;
    logic       b_valid, b_hs, b_vs, b_tick, b_fs;
    logic [9:0] b_col, b_row;

    int n_chk;
    int n_fail;

    vga_sync #(
        .CLK_DIV(2), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) u_dut_div2 (
        .clk(clk), .rst(rst), .o_pix_valid(a_valid), .o_col(a_col), .o_row(a_row),
        .o_hsync(a_hs), .o_vsync(a_vs), .o_pix_tick(a_tick), .o_frame_start(a_fs)
    );

    vga_sync #(
        .CLK_DIV(1), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) u_dut_div1 (
        .clk(clk), .rst(rst), .o_pix_valid(b_valid), .o_col(b_col), .o_row(b_row),
        .o_hsync(b_hs), .o_vsync(b_vs), .o_pix_tick(b_tick), .o_frame_start(b_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // s = clocks elapsed since the first edge after release; output shows raster position at s.
    function automatic exp_t model(input int s, input int div);
        exp_t e;
        int   p, d;
        p       = s / div;
        d       = s % div;
        e.col   = p % HT;
        e.row   = (p / HT) % VT;
        e.valid = (e.col < HV && e.row < VV) ? 1 : 0;
        e.hs    = (e.col >= HV + HF && e.col < HV + HF + HS) ? 0 : 1;
        e.vs    = (e.row >= VV + VF && e.row < VV + VF + VS) ? 0 : 1;
        e.tick  = (d == div - 1) ? 1 : 0;
        e.fs    = (e.col == 0 && e.row == 0 && d == 0) ? 1 : 0;
        return e;
    endfunction

    function automatic exp_t reset_vals();
        exp_t e;
        e.valid = 0; e.col = 0; e.row = 0; e.hs = 1; e.vs = 1; e.tick = 0; e.fs = 0;
        return e;
    endfunction

    task automatic check_both(input exp_t ea, input exp_t eb);
        check("div2.valid", {31'd0, a_valid}, ea.valid);
        check("div2.col",   {22'd0, a_col},   ea.col);
        check("div2.row",   {22'd0, a_row},   ea.row);
        check("div2.hsync", {31'd0, a_hs},    ea.hs);
        check("div2.vsync", {31'd0, a_vs},    ea.vs);
        check("div2.tick",  {31'd0, a_tick},  ea.tick);
        check("div2.fs",    {31'd0, a_fs},    ea.fs);
        check("div1.valid", {31'd0, b_valid}, eb.valid);
        check("div1.col",   {22'd0, b_col},   eb.col);
        check("div1.row",   {22'd0, b_row},   eb.row);
        check("div1.hsync", {31'd0, b_hs},    eb.hs);
        check("div1.vsync", {31'd0, b_vs},    eb.vs);
        check("div1.tick",  {31'd0, b_tick},  eb.tick);
        check("div1.fs",    {31'd0, b_fs},    eb.fs);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_both(reset_vals(), reset_vals());
        end

        for (int ep = 0; ep < 14; ep++) begin
            int run;
            int hold;
            rst = 1'b1;
            // First episode covers more than two full frames of the slower instance.
            run = (ep == 0) ? 520 : int'($urandom_range(1, 400));
            for (int i = 1; i <= run; i++) begin
                @(negedge clk);
                check_both(model(i - 1, 2), model(i - 1, 1));
            end
            #($urandom_range(1, 3));
            rst = 1'b0;
            #1;
            check_both(reset_vals(), reset_vals());
            hold = int'($urandom_range(1, 4));
            repeat (hold) begin
                @(negedge clk);
                check_both(reset_vals(), reset_vals());
            end
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
